quad_adc_sequencer: RTL

QUAD_ADC_SEQUENCER -- requirements
Module: quad_adc_sequencer

---
 rtl/quad_adc_pkg.sv | 21 ++
 rtl/quad_adc_frame_buf.sv | 42 ++++
 rtl/quad_adc_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/quad_adc_pkg.sv
// Shared definitions for the quad ADC sequencer: FSM state encoding,
// stream channel-id constants and default bus widths.
// No ports; imported by quad_adc_frame_buf and quad_adc_sequencer.
package quad_adc_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 14;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

  // Channel id carried in the top two bits of every stream word.
  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/quad_adc_frame_buf.sv
// Purpose: four-word holding register for one ADC frame plus channel-select mux.
// Latency: load takes effect on the next rising edge; word is combinational from sel.
// Backpressure: none internally; the owner holds sel steady while the word is stalled.
// Ports: clk/rst_n (async active-low), load + a/b/c/d_in (frame to hold),
//        sel (channel to present), word = {sel, held sample of that channel}.
module quad_adc_frame_buf
  import quad_adc_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  input  logic [DATA_WIDTH-1:0] c_in,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic [1:0]            sel,
  output logic [DATA_WIDTH+1:0] word
);

  logic [DATA_WIDTH-1:0] hold [4];
  logic [DATA_WIDTH-1:0] sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else if (load) begin
      hold[CH_A] <= a_in;
      hold[CH_B] <= b_in;
      hold[CH_C] <= c_in;
      hold[CH_D] <= d_in;
    end
  end

  always_comb begin
    sample = hold[sel];
  end

  assign word = {sel, sample};

endmodule

// File: rtl/quad_adc_sequencer.sv
// Purpose: capture SAMPLE_COUNT four-channel ADC frames and serialise them as {id, sample} stream words.
// Latency: first word valid one cycle after the accepted FRAME_VALID; one word per handshake.
// Backpressure: M_TREADY low holds the current word; frames arriving mid-emit are dropped and flag OVERFLOW.
// Ports: CLK, RESET_N (async active-low), START + SAMPLE_COUNT (capture request),
//        FRAME_VALID + CH_A..D_DATA (ADC frame), M_TDATA/M_TVALID/M_TREADY/M_TLAST (stream out),
//        BUSY (not idle), OVERFLOW (sticky frame drop).
// Build option: define QUAD_ADC_SEQ_TEST_PATTERN_EN to replace samples with a counting pattern.
module quad_adc_sequencer
  import quad_adc_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic [COUNT_WIDTH-1:0] SAMPLE_COUNT,
  input  logic                   FRAME_VALID,
  input  logic [DATA_WIDTH-1:0]  CH_A_DATA,
  input  logic [DATA_WIDTH-1:0]  CH_B_DATA,
  input  logic [DATA_WIDTH-1:0]  CH_C_DATA,
  input  logic [DATA_WIDTH-1:0]  CH_D_DATA,
  output logic [DATA_WIDTH+1:0]  M_TDATA,
  output logic                   M_TVALID,
  input  logic                   M_TREADY,
  output logic                   M_TLAST,
  output logic                   BUSY,
  output logic                   OVERFLOW
);

  state_t                 state_q, state_d;
  logic [1:0]             ch_q, ch_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] target_q, target_d;
  logic                   ovf_q, ovf_d;
  logic                   load;
  logic                   accept_start;
  logic                   hs;
  logic                   final_frame;
  logic [DATA_WIDTH-1:0]  a_in, b_in, c_in, d_in;

  assign accept_start = (state_q == ST_IDLE) && START && (SAMPLE_COUNT != '0);
  assign hs           = M_TVALID && M_TREADY;
  // The counter already includes the frame being emitted, so equality marks the last one.
  assign final_frame  = (cnt_q == target_q);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      ch_q     <= CH_A;
      cnt_q    <= '0;
      target_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    ovf_d    = ovf_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_start) begin
          target_d = SAMPLE_COUNT;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (FRAME_VALID) begin
          load    = 1'b1;
          cnt_d   = cnt_q + COUNT_WIDTH'(1);
          ch_d    = CH_A;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (hs) ch_d = ch_q + 2'd1;
        if (hs && (ch_q == CH_D)) begin
          if (final_frame) begin
            state_d = ST_IDLE;
          end else if (FRAME_VALID) begin
            // Back-to-back frame: the buffer frees exactly as the new one lands.
            load  = 1'b1;
            cnt_d = cnt_q + COUNT_WIDTH'(1);
          end else begin
            state_d = ST_CAPTURE;
          end
        end else if (FRAME_VALID) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef QUAD_ADC_SEQ_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic                  unused_ch;

  assign unused_ch = ^{CH_A_DATA, CH_B_DATA, CH_C_DATA, CH_D_DATA};

  always_comb begin
    pat_d = pat_q;
    if (accept_start)  pat_d = '0;
    else if (load)     pat_d = pat_q + DATA_WIDTH'(4);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) pat_q <= '0;
    else          pat_q <= pat_d;
  end

  assign a_in = pat_q;
  assign b_in = pat_q + DATA_WIDTH'(1);
  assign c_in = pat_q + DATA_WIDTH'(2);
  assign d_in = pat_q + DATA_WIDTH'(3);
`else
  assign a_in = CH_A_DATA;
  assign b_in = CH_B_DATA;
  assign c_in = CH_C_DATA;
  assign d_in = CH_D_DATA;
`endif

  quad_adc_frame_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_frame_buf (
    .clk   (CLK),
    .rst_n (RESET_N),
    .load  (load),
    .a_in  (a_in),
    .b_in  (b_in),
    .c_in  (c_in),
    .d_in  (d_in),
    .sel   (ch_q),
    .word  (M_TDATA)
  );

  assign M_TVALID = (state_q == ST_EMIT);
  assign M_TLAST  = M_TVALID && (ch_q == CH_D) && final_frame;
  assign BUSY     = (state_q != ST_IDLE);
  assign OVERFLOW = ovf_q;

endmodule
